// File: rtl/uart_tx_arb.sv
// Two-requester byte arbiter in front of a UART transmitter: round-robin grants,
// multi-byte lock frames, tx_done timeout and an inter-byte idle gap.
//
// state | meaning
// IDLE  | link free; arbitrate between eligible requesters
// WAIT  | byte handed to UART_tx; waiting for tx_done or timeout
// GAP   | post-byte idle spacing before the next grant
module uart_tx_arb #(
   parameter int GAP_CYC = 2,
   parameter int TO_CYC  = 8192
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic       req1,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   input  logic       lock0,
   input  logic       lock1,
   output logic       ack0,
   output logic       ack1,
   output logic       done0,
   output logic       done1,
   output logic       trmt,
   output logic [7:0] tx_data,
   input  logic       tx_done,
   output logic       busy,
   output logic       owner,
   output logic       timeout_err,
   input  logic       err_clr
);

   typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

   localparam logic [15:0] TO_LAST  = 16'(TO_CYC - 1);
   localparam logic [7:0]  GAP_LAST = (GAP_CYC > 0) ? 8'(GAP_CYC - 1) : 8'd0;

   state_t      state;
   logic        lock_flg;
   logic [15:0] wait_cnt;
   logic [7:0]  gap_cnt;

   logic owner_lock;
   logic elig0;
   logic elig1;
   logic gnt_any;
   logic gnt_sel;

   // A held lock restricts eligibility to the current owner only.
   always_comb begin
      owner_lock = owner ? lock1 : lock0;
      elig0      = req0 && (!lock_flg || !owner);
      elig1      = req1 && (!lock_flg || owner);
      gnt_any    = elig0 || elig1;
      if (elig0 && elig1) gnt_sel = ~owner;
      else                gnt_sel = elig1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         lock_flg    <= 1'b0;
         wait_cnt    <= 16'd0;
         gap_cnt     <= 8'd0;
         trmt        <= 1'b0;
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         done0       <= 1'b0;
         done1       <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         tx_data     <= 8'd0;
         owner       <= 1'b1;
      end else begin
         trmt  <= 1'b0;
         ack0  <= 1'b0;
         ack1  <= 1'b0;
         done0 <= 1'b0;
         done1 <= 1'b0;
         if (err_clr) timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (gnt_any) begin
                  tx_data  <= gnt_sel ? data1 : data0;
                  trmt     <= 1'b1;
                  ack0     <= ~gnt_sel;
                  ack1     <= gnt_sel;
                  owner    <= gnt_sel;
                  lock_flg <= gnt_sel ? lock1 : lock0;
                  wait_cnt <= 16'd0;
                  busy     <= 1'b1;
                  state    <= WAIT;
               end else if (!owner_lock) begin
                  lock_flg <= 1'b0;
               end
            end
            WAIT: begin
               if (tx_done) begin
                  done0    <= ~owner;
                  done1    <= owner;
                  wait_cnt <= 16'd0;
                  if (GAP_CYC == 0) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     gap_cnt <= GAP_LAST;
                     state   <= GAP;
                  end
               end else if (wait_cnt == TO_LAST) begin
                  // abort: the set here overrides a coincident err_clr above
                  timeout_err <= 1'b1;
                  lock_flg    <= 1'b0;
                  wait_cnt    <= 16'd0;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            GAP: begin
               if (gap_cnt == 8'd0) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt - 8'd1;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: requester byte queues and a UART_tx stub drive the DUT while a
// transaction-level model predicts every output each clock.
module tb_uart_tx_arb;
   localparam int GAP = 2;
   localparam int TO  = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, req1, lock0, lock1, tx_done, err_clr;
   logic [7:0] data0, data1;
   logic       ack0, ack1, done0, done1, trmt, busy, owner, timeout_err;
   logic [7:0] tx_data;

   always #5 clk = ~clk;

   uart_tx_arb #(.GAP_CYC(GAP), .TO_CYC(TO)) dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
      .lock0(lock0), .lock1(lock1), .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
      .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done), .busy(busy), .owner(owner),
      .timeout_err(timeout_err), .err_clr(err_clr)
   );

   int vectors = 0;
   int miscompares = 0;

   // requester byte queues: bit 8 is the lock level presented with that byte
   logic [8:0] q0[$];
   logic [8:0] q1[$];
   int  hold0 = 0, hold1 = 0;
   bit  rand_gap = 0, auto_done = 1, spur_en = 1, td_force = 0;

   // model: en is the index of the next rising edge
   int  en = 0, m_ge = 0, m_free = 0, td_edge = -1;
   bit  m_send = 0, m_lock = 0, m_owner = 1, m_err = 0;
   bit  e_trmt = 0, e_ack0 = 0, e_ack1 = 0, e_done0 = 0, e_done1 = 0, e_busy = 0;
   logic [7:0] e_data = 8'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("trmt",        32'(trmt),        32'(e_trmt));
      chk("ack0",        32'(ack0),        32'(e_ack0));
      chk("ack1",        32'(ack1),        32'(e_ack1));
      chk("done0",       32'(done0),       32'(e_done0));
      chk("done1",       32'(done1),       32'(e_done1));
      chk("tx_data",     32'(tx_data),     32'(e_data));
      chk("owner",       32'(owner),       32'(m_owner));
      chk("busy",        32'(busy),        32'(e_busy));
      chk("timeout_err", 32'(timeout_err), 32'(m_err));
   endtask

   task automatic tick();
      bit c0, c1, g, set_err;
      logic [8:0] b;
      if (hold0 > 0) hold0--;
      if (hold1 > 0) hold1--;
      req0  = (q0.size() > 0) && (hold0 == 0);
      req1  = (q1.size() > 0) && (hold1 == 0);
      data0 = req0 ? q0[0][7:0] : 8'($urandom);
      data1 = req1 ? q1[0][7:0] : 8'($urandom);
      lock0 = req0 ? q0[0][8] : 1'b0;
      lock1 = req1 ? q1[0][8] : 1'b0;
      if (m_send) tx_done = (en == td_edge);
      else        tx_done = td_force || (spur_en && $urandom_range(0, 3) == 0);
      td_force = 0;

      e_trmt = 0; e_ack0 = 0; e_ack1 = 0; e_done0 = 0; e_done1 = 0;
      set_err = 0;
      if (m_send) begin
         if (tx_done) begin
            if (m_owner) e_done1 = 1; else e_done0 = 1;
            m_send = 0;
            m_free = en + GAP + 1;
         end else if (en == m_ge + TO) begin
            m_send = 0; m_lock = 0; set_err = 1;
            m_free = en + 1;
         end
      end else if (en >= m_free) begin
         c0 = req0 && !(m_lock && m_owner == 1'b1);
         c1 = req1 && !(m_lock && m_owner == 1'b0);
         if (c0 || c1) begin
            g = (c0 && c1) ? !m_owner : c1;
            if (g) begin
               b = q1.pop_front(); e_ack1 = 1;
               if (rand_gap && !b[8]) hold1 = $urandom_range(1, 4);
            end else begin
               b = q0.pop_front(); e_ack0 = 1;
               if (rand_gap && !b[8]) hold0 = $urandom_range(1, 4);
            end
            e_trmt = 1; e_data = b[7:0];
            m_owner = g; m_lock = b[8]; m_send = 1; m_ge = en;
            td_edge = auto_done ? en + int'($urandom_range(1, 8)) : -1;
         end else if (m_lock && !(m_owner ? lock1 : lock0)) begin
            m_lock = 0;
         end
      end
      if (set_err) m_err = 1;
      else if (err_clr) m_err = 0;
      e_busy = m_send || (en < m_free - 1);
      en++;
      @(negedge clk);
      check_outputs();
   endtask

   // asynchronous reset asserted between edges, held across one edge
   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      q0.delete(); q1.delete();
      hold0 = 0; hold1 = 0; td_edge = -1;
      m_send = 0; m_lock = 0; m_owner = 1; m_err = 0; m_free = 0;
      e_trmt = 0; e_ack0 = 0; e_ack1 = 0; e_done0 = 0; e_done1 = 0; e_busy = 0;
      e_data = 8'd0;
      req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; tx_done = 0; err_clr = 0;
      check_outputs();
      @(negedge clk);
      en++;
      check_outputs();
      rst = 1'b0;
   endtask

   initial begin
      int guard;
      int len;
      bit who;
      rst = 1'b1;
      req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; tx_done = 0; err_clr = 0;
      data0 = 8'd0; data1 = 8'd0;
      #1 check_outputs();
      @(negedge clk);
      rst = 1'b0;

      // single byte from reset
      q0.push_back({1'b0, 8'h47});
      repeat (14) tick();

      // contention from reset: alternate 0,1,0,1
      do_reset();
      q0.push_back({1'b0, 8'hA1}); q0.push_back({1'b0, 8'hA2});
      q1.push_back({1'b0, 8'hB1}); q1.push_back({1'b0, 8'hB2});
      repeat (60) tick();

      // locked 3-byte frame from requester 1 while requester 0 waits
      q1.push_back({1'b1, 8'h53}); q1.push_back({1'b1, 8'h47}); q1.push_back({1'b1, 8'h30});
      tick();
      q0.push_back({1'b0, 8'h99});
      repeat (60) tick();

      // timeout, clear, then timeout coinciding with a held clear
      auto_done = 0;
      q0.push_back({1'b1, 8'h3C});
      repeat (20) tick();
      err_clr = 1; tick();
      err_clr = 0; tick();
      q1.push_back({1'b0, 8'hC3});
      err_clr = 1;
      repeat (20) tick();
      err_clr = 0; tick();

      // reset while waiting on a locked byte, then a stray tx_done
      q0.push_back({1'b1, 8'h5A});
      repeat (3) tick();
      do_reset();
      auto_done = 1;
      td_force = 1; tick();
      q0.push_back({1'b0, 8'h11});
      repeat (14) tick();

      // randomized frames from both requesters
      rand_gap = 1;
      for (int f = 0; f < 40; f++) begin
         who = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 3);
         for (int k = 0; k < len; k++) begin
            if (who) q1.push_back({(k != len - 1), 8'($urandom)});
            else     q0.push_back({(k != len - 1), 8'($urandom)});
         end
      end
      guard = 0;
      while (!(q0.size() == 0 && q1.size() == 0 && !m_send && en >= m_free) && guard < 3000) begin
         tick();
         guard++;
      end
      chk("drain_bound", 32'(guard < 3000), 32'd1);
      repeat (5) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter GAP_CYC, default 2: idle clocks inserted after each byte's tx_done before the next grant; legal range 0..255.
REQ-002 SHALL have parameter TO_CYC, default 8192: clocks allowed from trmt to tx_done before abort; legal range 1..65535.
REQ-003 SHALL have port clk  in  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports req0 / req1  in  1  requester 0/1 has a byte pending; held until its ack.
REQ-006 SHALL have ports data0 / data1  in  8  requester byte; stable while the matching req is high.
REQ-007 SHALL have ports lock0 / lock1  in  1  requester holds the link exclusively across bytes (multi-byte frame).
REQ-008 SHALL have ports ack0 / ack1  out  1  one-clock pulse: byte captured, requester may change data or drop req.
REQ-009 SHALL have ports done0 / done1  out  1  one-clock pulse: the requester's byte has finished serialising.
REQ-010 SHALL have port trmt  out  1  one-clock start pulse to UART_tx.
REQ-011 SHALL have port tx_data  out  8  byte to UART_tx; registered.
REQ-012 SHALL have port tx_done  in  1  UART_tx byte-complete indication.
REQ-013 SHALL have port busy  out  1  high in every state except IDLE.
REQ-014 SHALL have port owner  out  1  index of the last granted requester.
REQ-015 SHALL have port timeout_err  out  1  sticky abort flag.
REQ-016 SHALL have port err_clr  in  1  clears timeout_err.

Function
REQ-017 SHALL implement the states IDLE, WAIT and GAP.
REQ-018 SHALL, in IDLE at an edge where an eligible req is high: load tx_data from that requester's data, assert trmt and that requester's ack for exactly the next clock, set owner, and go to WAIT.
REQ-019 SHALL decide eligibility as follows: with no lock held, both requesters are eligible; when both request, the one not equal to owner wins (round-robin); a single request wins outright.
REQ-020 SHALL set the lock flag when the granted requester's lock is high at its grant edge; while the flag is set, only owner is eligible.
REQ-021 SHALL clear the lock flag at any IDLE edge where the owner's lock is low.
REQ-022 SHALL run a 16-bit counter in WAIT, cleared at the grant edge; on tx_done it pulses done[owner] for one clock and goes to GAP.
REQ-023 SHALL, in WAIT when the counter reaches TO_CYC with no tx_done: go to IDLE, set timeout_err, clear the lock flag, and issue no done pulse.
REQ-024 SHALL stay in GAP for GAP_CYC clocks, then go to IDLE; when GAP_CYC=0, GAP lasts zero clocks and WAIT goes directly to IDLE.
REQ-025 SHALL ignore tx_done in IDLE and in GAP.
REQ-026 SHALL clear timeout_err on err_clr; set SHALL win when set and clear coincide.
REQ-027 SHALL hold tx_data constant from grant until the next grant.
REQ-028 SHALL never have ack0 and ack1 high together, nor done0 and done1 high together.
REQ-029 SHALL produce a minimum req-to-trmt latency of 1 clock, and byte-to-byte spacing of tx_done + GAP_CYC + 1 clocks.
REQ-030 SHALL treat a req still high after its ack as a new byte at the next IDLE arbitration.

Reset
REQ-031 SHALL, on rst, immediately force: state IDLE; trmt, ack0, ack1, done0, done1, busy, timeout_err and tx_data all 0; lock flag cleared; counters 0.
REQ-032 SHALL reset owner to 1, so that requester 0 wins the first contention.
REQ-033 SHALL abandon any in-flight byte when rst is asserted mid-operation, issuing no done pulse.

Verification
REQ-034 SHALL check: req0 with data0=8'h47 from reset -> trmt and ack0 one clock later, tx_data=8'h47, done0 one clock after tx_done, busy low GAP_CYC clocks later.
REQ-035 SHALL check: req0 and req1 held high together with locks low -> grants alternate 0,1,0,1 and owner toggles on each grant.
REQ-036 SHALL check: lock1 high for a 3-byte frame (8'h53, 8'h47, 8'h30) while req0 is high -> three consecutive req1 grants, then req0 is granted once lock1 drops.
REQ-037 SHALL check: tx_done withheld, TO_CYC=16 -> return to IDLE 16 clocks after trmt, timeout_err=1, no done pulse; err_clr then drives timeout_err to 0.
REQ-038 SHALL check: rst asserted in WAIT -> all outputs 0 immediately, owner=1; a later tx_done pulse produces no done pulse.
REQ-039 SHALL check: tx_done pulsed in IDLE and in GAP -> no state change and no done pulse.
